// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
package serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_rca.sv
// 4-bit ripple-carry adder slice shared across all nibbles of an operation.
module ripple_carry_adder
    import serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequencer that reuses one 4-bit adder slice, LSB nibble first,
// with valid/ready handshakes on operands and result.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  res_reg;
    logic [WIDTH-1:0]  res_next;
    logic              carry;
    logic              a_msb;
    logic              b_msb;
    logic              ovf_reg;
    logic [CNT_W-1:0]  cnt;
    logic [NIBBLE_W-1:0] slice_sum;
    logic              slice_cout;
    logic              last_nibble;

    ripple_carry_adder u_slice (
        .a    (a_reg[NIBBLE_W-1:0]),
        .b    (b_reg[NIBBLE_W-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Each slice result enters at the top so the first (LSB) nibble ends at the bottom.
    if (WIDTH == NIBBLE_W) begin : g_single
        assign res_next = slice_sum;
    end else begin : g_multi
        assign res_next = {slice_sum, res_reg[WIDTH-1:NIBBLE_W]};
    end

    assign last_nibble = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so the inversion and the forced carry happen at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            ovf_reg <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> NIBBLE_W;
                    b_reg   <= b_reg >> NIBBLE_W;
                    res_reg <= res_next;
                    carry   <= slice_cout;
                    cnt     <= cnt + 1'b1;
                    if (last_nibble) begin
                        ovf_reg <= (a_msb == b_msb) && (slice_sum[NIBBLE_W-1] != a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum      = res_reg;
    assign cout     = carry;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: arithmetic reference model plus directed vectors.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    logic prev_ov = 1'b0;
    exp_t exp_q[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mcin, input logic msub);
        exp_t             r;
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   full;
        be   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + (WIDTH + 1)'(msub ? 1'b1 : mcin);
        r.s  = full[WIDTH-1:0];
        r.c  = full[WIDTH];
        r.v  = (ma[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        return r;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] es,
                               input logic ec, input logic ev);
        checkValue({name, "_valid"}, 32'(out_valid), 32'd1);
        checkValue({name, "_sum"}, 32'(sum), 32'(es));
        checkValue({name, "_cout"}, 32'(cout), 32'(ec));
        checkValue({name, "_ovf"}, 32'(overflow), 32'(ev));
    endtask

    // Scoreboard feed: record an expected result on every accepted operand pair.
    always @(posedge clk) begin
        cyc++;
        if (rst !== 1'b1) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                acc_cyc = cyc;
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge rst) exp_q.delete();

    // Every cycle the result is presented, it must match the model and arrive on time.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out_valid: got out_valid=1, expected 0");
            end else begin
                checkValue("model_sum", 32'(sum), 32'(exp_q[0].s));
                checkValue("model_cout", 32'(cout), 32'(exp_q[0].c));
                checkValue("model_ovf", 32'(overflow), 32'(exp_q[0].v));
                checkValue("model_in_ready", 32'(in_ready), 32'd0);
            end
            if (!prev_ov) begin
                checkValue("latency", 32'(cyc - acc_cyc), 32'd4);
            end
        end
        prev_ov = (rst === 1'b0) && out_valid;
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                                 input logic scin, input logic ssub);
        bit ready_seen;
        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ready_seen = 1'b1;
                break;
            end
        end
        if (!ready_seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got in_ready=0, expected 1");
        end
        a        = sa;
        b        = sb;
        cin      = scin;
        sub      = ssub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic waitResult(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_valid_timeout: got out_valid=0, expected 1");
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkValue({name, "_ov_drop"}, 32'(out_valid), 32'd0);
        checkValue({name, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic runOp(input string name, input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                         input logic scin, input logic ssub,
                         input logic [WIDTH-1:0] es, input logic ec, input logic ev);
        bit ok;
        applyStimulus(sa, sb, scin, ssub);
        waitResult(ok);
        if (ok) begin
            checkOutput(name, es, ec, ev);
            consume(name);
        end
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_in_ready", 32'(in_ready), 32'd1);
        checkValue("reset_out_valid", 32'(out_valid), 32'd0);
        checkValue("reset_sum", 32'(sum), 32'd0);
        checkValue("reset_cout", 32'(cout), 32'd0);
        checkValue("reset_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        runOp("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        runOp("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp("add_cin", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
        runOp("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        runOp("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        runOp("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Back-pressure: result must hold while the consumer stalls and inputs wiggle.
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
        waitResult(ok);
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("hold", 16'h2345, 1'b0, 1'b0);
                checkValue("hold_in_ready", 32'(in_ready), 32'd0);
                in_valid = ~in_valid;
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
                @(negedge clk);
            end
            checkOutput("hold_end", 16'h2345, 1'b0, 1'b0);
            in_valid = 1'b0;
            consume("hold");
        end

        // Abort during the second RUN cycle; the operation must vanish.
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkValue("abort_in_ready", 32'(in_ready), 32'd1);
        checkValue("abort_out_valid", 32'(out_valid), 32'd0);
        checkValue("abort_sum", 32'(sum), 32'd0);
        checkValue("abort_cout", 32'(cout), 32'd0);
        checkValue("abort_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkValue("abort_no_result", 32'(out_valid), 32'd0);
        end
        runOp("after_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
